wrap_addsub_pipe: RTL

Parametrised two-stage pipelined add/subtract unit with modulo wrap-around, used by the snake position and score datapath. Replaces fixed-width ripple adders where the result must stay within a grid dimension (0..MODULUS-1). It accepts one operation per cycle under a valid/ready handshake, supports backpressure, and reports carry/borrow and wrap flags alongside the result.

---
 rtl/wrap_addsub_pipe_if.sv | 25 ++
 rtl/wrap_addsub_pipe.sv | 96 +++++++++
 2 files changed

// File: rtl/wrap_addsub_pipe_if.sv
// rtl/wrap_addsub_pipe_if.sv - operand/result handshake bundle for wrap_addsub_pipe
interface wrap_addsub_pipe_if #(
    parameter int WIDTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_wrapped;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_wrapped
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_wrapped
    );
endinterface

// File: rtl/wrap_addsub_pipe.sv
// rtl/wrap_addsub_pipe.sv - two-stage add/subtract with single modulo correction
module wrap_addsub_pipe #(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 20
) (
    input  logic                clk,
    input  logic                rst,
    wrap_addsub_pipe_if.slave   bus
);
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
    // When MODULUS == 2**WIDTH this truncates to 0 and the borrow fix-up is a no-op.
    localparam logic [WIDTH-1:0] MOD_TRUNC = WIDTH'(MODULUS);

    logic             v1_q, v1_d;
    logic [WIDTH:0]   raw_q, raw_d;
    logic             sub1_q, sub1_d;
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             wrapped_q, wrapped_d;

    logic             in_ready;
    logic             xfer_in;
    logic             adv2;

    always_comb begin
        in_ready  = !rst && (!v1_q || !v2_q || bus.out_ready);
        xfer_in   = bus.in_valid && in_ready;
        adv2      = v1_q && (!v2_q || bus.out_ready);

        v1_d      = xfer_in ? 1'b1 : (adv2 ? 1'b0 : v1_q);
        raw_d     = raw_q;
        sub1_d    = sub1_q;
        if (xfer_in) begin
            sub1_d = bus.in_sub;
            if (bus.in_sub) begin
                raw_d = {1'b0, bus.in_a} + {1'b0, ~bus.in_b} + (WIDTH+1)'(1);
            end else begin
                raw_d = {1'b0, bus.in_a} + {1'b0, bus.in_b};
            end
        end

        v2_d      = adv2 ? 1'b1 : (bus.out_ready ? 1'b0 : v2_q);
        sum_d     = sum_q;
        carry_d   = carry_q;
        wrapped_d = wrapped_q;
        if (adv2) begin
            if (!sub1_q) begin
                carry_d = raw_q[WIDTH];
                if (raw_q >= MOD_EXT) begin
                    sum_d     = WIDTH'(raw_q - MOD_EXT);
                    wrapped_d = 1'b1;
                end else begin
                    sum_d     = raw_q[WIDTH-1:0];
                    wrapped_d = 1'b0;
                end
            end else begin
                // raw[WIDTH] clear means a < b: pull the negative result back into range.
                carry_d = !raw_q[WIDTH];
                if (!raw_q[WIDTH]) begin
                    sum_d     = raw_q[WIDTH-1:0] + MOD_TRUNC;
                    wrapped_d = 1'b1;
                end else begin
                    sum_d     = raw_q[WIDTH-1:0];
                    wrapped_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            raw_q     <= '0;
            sub1_q    <= 1'b0;
            v2_q      <= 1'b0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            raw_q     <= raw_d;
            sub1_q    <= sub1_d;
            v2_q      <= v2_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = v2_q;
    assign bus.out_sum     = sum_q;
    assign bus.out_carry   = carry_q;
    assign bus.out_wrapped = wrapped_q;
endmodule
